// File: rtl/ibex_bist_pkg.sv
// Shared types and constants for the BIST/safety APB path of the execution block.
package ibex_bist_pkg;

    localparam int unsigned DATA_W              = 32;
    localparam int unsigned APB_TIMEOUT_DEFAULT = 16;

    localparam logic [31:0] BIST_CTRL    = 32'h0000_0000;
    localparam logic [31:0] BIST_STATUS  = 32'h0000_0004;
    localparam logic [31:0] BIST_IRQ_CLR = 32'h0000_0008;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/ibex_bist_apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB transfer out,
// valid/ready response back, with a hung-completer timeout.
module ibex_bist_apb_master
    import ibex_bist_pkg::*;
#(
    parameter int unsigned TimeoutCycles = APB_TIMEOUT_DEFAULT,
    parameter int unsigned AddrWidth     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic                 cmd_write_i,
    input  logic [DATA_W-1:0]    cmd_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_W-1:0]    rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DATA_W-1:0]    pwdata_o,
    input  logic [DATA_W-1:0]    prdata_i,
    input  logic                 pready_i,
    input  logic                 pslverr_i,
    output logic                 busy_o
);

    localparam int unsigned CntW   = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
    localparam int unsigned ToLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;

    apb_mst_state_e        r_state, w_state_d;
    logic [AddrWidth-1:0]  r_paddr, w_paddr_d;
    logic                  r_psel, w_psel_d;
    logic                  r_penable, w_penable_d;
    logic                  r_pwrite, w_pwrite_d;
    logic [DATA_W-1:0]     r_pwdata, w_pwdata_d;
    logic                  r_rsp_valid, w_rsp_valid_d;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_d;
    logic                  r_rsp_err, w_rsp_err_d;
    logic                  r_rsp_timeout, w_rsp_timeout_d;
    logic [CntW-1:0]       r_cnt, w_cnt_d;
    logic                  r_busy;

    // State and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_paddr       <= w_paddr_d;
            r_psel        <= w_psel_d;
            r_penable     <= w_penable_d;
            r_pwrite      <= w_pwrite_d;
            r_pwdata      <= w_pwdata_d;
            r_rsp_valid   <= w_rsp_valid_d;
            r_rsp_rdata   <= w_rsp_rdata_d;
            r_rsp_err     <= w_rsp_err_d;
            r_rsp_timeout <= w_rsp_timeout_d;
            r_cnt         <= w_cnt_d;
            r_busy        <= (w_state_d != IDLE);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_d       = r_state;
        w_paddr_d       = r_paddr;
        w_psel_d        = r_psel;
        w_penable_d     = r_penable;
        w_pwrite_d      = r_pwrite;
        w_pwdata_d      = r_pwdata;
        w_rsp_valid_d   = r_rsp_valid;
        w_rsp_rdata_d   = r_rsp_rdata;
        w_rsp_err_d     = r_rsp_err;
        w_rsp_timeout_d = r_rsp_timeout;
        w_cnt_d         = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_paddr_d  = cmd_addr_i;
                    w_pwrite_d = cmd_write_i;
                    w_pwdata_d = cmd_wdata_i;
                    // Misaligned commands are answered locally without touching the bus
                    if (cmd_addr_i[1:0] != 2'b00) begin
                        w_state_d       = RESP;
                        w_rsp_valid_d   = 1'b1;
                        w_rsp_rdata_d   = '0;
                        w_rsp_err_d     = 1'b1;
                        w_rsp_timeout_d = 1'b0;
                    end else begin
                        w_state_d = SETUP;
                        w_psel_d  = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_state_d   = ACCESS;
                w_penable_d = 1'b1;
                w_cnt_d     = '0;
            end
            ACCESS: begin
                if (pready_i) begin
                    w_state_d       = RESP;
                    w_psel_d        = 1'b0;
                    w_penable_d     = 1'b0;
                    w_rsp_valid_d   = 1'b1;
                    w_rsp_rdata_d   = (r_pwrite || pslverr_i) ? '0 : prdata_i;
                    w_rsp_err_d     = pslverr_i;
                    w_rsp_timeout_d = 1'b0;
                end else if ((TimeoutCycles != 0) && (r_cnt == CntW'(ToLast))) begin
                    w_state_d       = RESP;
                    w_psel_d        = 1'b0;
                    w_penable_d     = 1'b0;
                    w_rsp_valid_d   = 1'b1;
                    w_rsp_rdata_d   = '0;
                    w_rsp_err_d     = 1'b1;
                    w_rsp_timeout_d = 1'b1;
                end else begin
                    w_cnt_d = CntW'(r_cnt + 1'b1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_state_d     = IDLE;
                    w_rsp_valid_d = 1'b0;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign cmd_ready_o   = (r_state == IDLE);
    assign busy_o        = r_busy;
    assign paddr_o       = r_paddr;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign pwdata_o      = r_pwdata;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_ibex_bist_apb_master.sv
// Directed bench for ibex_bist_apb_master: vector table of single transfers
// plus hand-written backpressure and mid-transfer reset sequences.
module tb_ibex_bist_apb_master;
    import ibex_bist_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i;
    logic        cmd_write_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_bist_apb_master #(.TimeoutCycles(16), .AddrWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;      // ACCESS cycles before pready; large = never
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_lat;    // cycles from accept to rsp_valid
        int          exp_acc;    // ACCESS cycles seen on the bus
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  lat;
        int  acc;
        bit  done;
        lat  = 0;
        acc  = 0;
        done = 0;
        chk("idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_addr_i  = v.addr;
        cmd_write_i = v.write;
        cmd_wdata_i = v.wdata;
        prdata_i    = v.prdata;
        pslverr_i   = v.slverr;
        pready_i    = 1'b0;
        while (!done) begin
            tick();
            lat++;
            cmd_valid_i = 1'b0;
            pready_i    = 1'b0;
            if (rsp_valid_o) begin
                done = 1;
            end else if (lat > 40) begin
                n_fail++;
                $display("FAIL rsp_wait_bound addr=0x%08h no response after %0d cycles", v.addr, lat);
                done = 1;
            end else begin
                if (lat == 1) begin
                    chk("setup_psel", 32'(psel_o), 32'(v.exp_acc != 0));
                    chk("setup_penable", 32'(penable_o), 32'd0);
                end
                if (psel_o) begin
                    chk("paddr_stable", paddr_o, v.addr);
                    chk("pwrite_stable", 32'(pwrite_o), 32'(v.write));
                    chk("pwdata_stable", pwdata_o, v.wdata);
                end
                if (penable_o) begin
                    chk("penable_needs_psel", 32'(psel_o), 32'd1);
                    pready_i = (acc == v.waits);
                    acc++;
                end
            end
        end
        chk("rsp_latency", 32'(lat), 32'(v.exp_lat));
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk("rsp_rdata", rsp_rdata_o, v.exp_rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
        chk("rsp_timeout", 32'(rsp_timeout_o), 32'(v.exp_to));
        chk("resp_psel_low", 32'(psel_o), 32'd0);
        chk("resp_cmd_ready", 32'(cmd_ready_o), 32'd0);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("post_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [31:0] held_rdata;

        //             wr    addr            wdata          wt   prdata         err   rdata          e  to lat acc
        vecs[0] = '{1'b1, BIST_CTRL,      32'h0000_0001,   0, 32'h1234_5678, 1'b0, 32'h0,         0, 0,  3,  1};
        vecs[1] = '{1'b0, BIST_STATUS,    32'h0,           3, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 0, 0,  6,  4};
        vecs[2] = '{1'b0, BIST_STATUS,    32'h0,         100, 32'h5555_5555, 1'b0, 32'h0,         1, 1, 18, 16};
        vecs[3] = '{1'b0, BIST_STATUS,    32'h0,          15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 0, 0, 18, 16};
        vecs[4] = '{1'b0, 32'h0000_0006,  32'h0,           0, 32'h1111_1111, 1'b0, 32'h0,         1, 0,  1,  0};
        vecs[5] = '{1'b0, BIST_IRQ_CLR,   32'h0,           1, 32'h0,         1'b1, 32'h0,         1, 0,  4,  2};
        vecs[6] = '{1'b1, 32'h0000_0104,  32'hA5A5_5A5A,   2, 32'h7777_7777, 1'b0, 32'h0,         0, 0,  5,  3};
        vecs[7] = '{1'b1, 32'h0000_0003,  32'hFFFF_FFFF,   0, 32'h0,         1'b0, 32'h0,         1, 0,  1,  0};

        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_write_i = 1'b0;
        cmd_wdata_i = '0;
        rsp_ready_i = 1'b0;
        prdata_i    = '0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;

        tick();
        tick();
        chk("rst_psel", 32'(psel_o), 32'd0);
        chk("rst_penable", 32'(penable_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rel_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Response backpressure with a second command waiting
        cmd_valid_i = 1'b1;
        cmd_addr_i  = BIST_STATUS;
        cmd_write_i = 1'b0;
        prdata_i    = 32'h0BAD_F00D;
        pslverr_i   = 1'b0;
        tick();                      // SETUP
        tick();                      // ACCESS
        chk("bp_penable", 32'(penable_o), 32'd1);
        pready_i = 1'b1;
        tick();                      // RESP, cmd_valid still high for the next command
        pready_i   = 1'b0;
        cmd_addr_i = BIST_CTRL;
        held_rdata = 32'h0BAD_F00D;
        chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
            chk("bp_rdata_stable", rsp_rdata_o, held_rdata);
            chk("bp_err_stable", 32'(rsp_err_o), 32'd0);
            chk("bp_valid_held", 32'(rsp_valid_o), 32'd1);
            chk("bp_no_psel", 32'(psel_o), 32'd0);
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();                      // IDLE: second command accepted this cycle
        rsp_ready_i = 1'b0;
        chk("bp_rsp_cleared", 32'(rsp_valid_o), 32'd0);
        chk("bp_second_ready", 32'(cmd_ready_o), 32'd1);
        prdata_i = 32'h0000_00C3;
        tick();                      // SETUP of second command
        cmd_valid_i = 1'b0;
        chk("bp_second_psel", 32'(psel_o), 32'd1);
        chk("bp_second_paddr", paddr_o, BIST_CTRL);
        tick();                      // ACCESS
        pready_i = 1'b1;
        tick();                      // RESP
        pready_i = 1'b0;
        chk("bp_second_valid", 32'(rsp_valid_o), 32'd1);
        chk("bp_second_rdata", rsp_rdata_o, 32'h0000_00C3);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;

        // Reset in the middle of a stalled ACCESS
        cmd_valid_i = 1'b1;
        cmd_addr_i  = BIST_STATUS;
        cmd_write_i = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_psel_before", 32'(psel_o), 32'd1);
        chk("mid_penable_before", 32'(penable_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_psel_async", 32'(psel_o), 32'd0);
        chk("mid_penable_async", 32'(penable_o), 32'd0);
        chk("mid_rsp_valid_async", 32'(rsp_valid_o), 32'd0);
        chk("mid_busy_async", 32'(busy_o), 32'd0);
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("post_rst_busy", 32'(busy_o), 32'd0);
            chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
            chk("post_rst_psel", 32'(psel_o), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
